mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WORD, default `WORD (64), datapath width.
REQ-002 SHALL have parameter ADDR_LSB, default 3, number of low address bits that must be zero for an aligned access.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have these execute-side ports:
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  stage can accept.
- alu_result  in  WORD  ALU result or memory address.
- zero  in  1  ALU zero flag.
- branch_target  in  WORD  computed branch PC.
- store_data  in  WORD  store data.
- mem_read  in  1  load.
- mem_write  in  1  store.
- branch  in  1  conditional branch (CBZ).
- uncond_branch  in  1  unconditional branch.
- mem_to_reg  in  1  select load data for writeback.
- reg_write  in  1  writes rd.
- rd  in  5  destination register.
REQ-005 SHALL have these data-memory ports:
- dm_req  out  1  request.
- dm_we  out  1  write enable.
- dm_addr  out  WORD  address.
- dm_wdata  out  WORD  write data.
- dm_ack  in  1  completion.
- dm_rdata  in  WORD  read data, valid with dm_ack.
REQ-006 SHALL have these writeback-side ports:
- wb_valid  out  1  result valid.
- wb_ready  in  1  consumer ready.
- wb_data  out  WORD  writeback value.
- wb_rd  out  5  destination.
- wb_reg_write  out  1  write enable.
- wb_fault  out  1  alignment fault.
REQ-007 SHALL have these branch ports:
- pc_src  out  1  one-cycle taken-branch pulse.
- pc_target  out  WORD  redirect PC, valid with pc_src.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, RESP; ex_ready=1 only in IDLE; transfer occurs when ex_valid && ex_ready.
REQ-009 On transfer, SHALL register all execute-side inputs; when mem_read|mem_write, SHALL go to REQ, otherwise to RESP with wb_data=alu_result.
REQ-010 In REQ, SHALL hold dm_req=1, dm_we=mem_write, dm_addr=alu_result, dm_wdata=store_data stable until the cycle dm_ack=1, then go to RESP; mem_read and mem_write both set SHALL be treated as a store.
REQ-011 On dm_ack for a load, SHALL capture dm_rdata; wb_data = mem_to_reg ? captured data : alu_result.
REQ-012 SHALL force wb_reg_write=0 for stores, otherwise pass the registered reg_write.
REQ-013 In RESP, SHALL assert wb_valid with wb_data/wb_rd/wb_reg_write/wb_fault stable; on wb_ready=1, SHALL return to IDLE (ex_ready rises the next cycle).
REQ-014 Minimum latency, transfer to wb_valid: 1 cycle for non-memory ops; 2 cycles for memory ops with dm_ack in the first REQ cycle.
REQ-015 SHALL ignore dm_ack outside REQ.
REQ-016 SHALL assert pc_src for exactly the cycle after transfer when (branch&&zero)||uncond_branch, with pc_target = registered branch_target; otherwise pc_src=0 and pc_target holds its last value.
REQ-017 dm_req SHALL be 0 in IDLE and RESP.

Reset
REQ-018 While rst_n=0, the FSM SHALL be IDLE and ex_ready SHALL be 1.
REQ-019 While rst_n=0, dm_req, dm_we, wb_valid, wb_reg_write, wb_fault and pc_src SHALL be 0, and all data outputs SHALL be 0.
REQ-020 Reset asserted mid-REQ SHALL drop dm_req immediately; an in-flight access SHALL be abandoned and a later dm_ack ignored.

Configuration
REQ-021 With MEM_ALIGN_CHK_EN defined, an access whose alu_result[ADDR_LSB-1:0]!=0 SHALL issue no dm_req and SHALL go directly to RESP with wb_fault=1 and wb_reg_write=0.
REQ-022 Without MEM_ALIGN_CHK_EN, wb_fault SHALL be tied 0 and misaligned addresses SHALL be passed to memory unchanged.

Structure
REQ-023 The FSM state encoding and the WORD width SHALL reside in the shared definitions header/package.
REQ-024 Branch resolution (pc_src/pc_target logic) SHALL be a sub-module named branch_unit; all other logic SHALL be inline.

Verification
REQ-025 Bench SHALL cover ADD result alu_result=0x2A, reg_write=1, rd=5, wb_ready=1 -> wb_valid one cycle later, wb_data=0x2A, wb_rd=5.
REQ-026 Bench SHALL cover LDUR addr=0x100, mem_to_reg=1, dm_ack after 3 cycles with dm_rdata=0xDEAD -> dm_req high 3 cycles, dm_addr=0x100, wb_data=0xDEAD.
REQ-027 Bench SHALL cover STUR addr=0x108, store_data=0x55, reg_write=1 -> dm_we=1, dm_wdata=0x55, wb_reg_write=0.
REQ-028 Bench SHALL cover CBZ with zero=1, branch_target=0x40 -> pc_src pulse of one cycle with pc_target=0x40; with zero=0 -> pc_src stays 0.
REQ-029 Bench SHALL cover wb_ready held 0 for 4 cycles -> wb_valid and wb_data stable and ex_ready=0 throughout.
REQ-030 Bench SHALL cover, with MEM_ALIGN_CHK_EN defined, load at 0x103 -> no dm_req, wb_fault=1; and rst_n pulsed mid-REQ -> dm_req=0 immediately and ex_ready=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath width, FSM encoding, branch helper.
package mem_stage_pkg;

   localparam int unsigned MEM_WORD = 64;
   localparam int unsigned RD_W     = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic br_taken(input logic branch, input logic zero, input logic uncond);
      return (branch & zero) | uncond;
   endfunction

endpackage

// File: rtl/mem_stage_branch_unit.sv
// Branch resolution: one-cycle pc_src pulse after a taken transfer, sticky pc_target.
module branch_unit
   import mem_stage_pkg::*;
#(
   parameter int unsigned WORD = MEM_WORD
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            xfer_i,
   input  logic            branch_i,
   input  logic            uncond_branch_i,
   input  logic            zero_i,
   input  logic [WORD-1:0] target_i,
   output logic            pc_src_o,
   output logic [WORD-1:0] pc_target_o
);

   logic            pc_src_q;
   logic [WORD-1:0] pc_target_q;
   logic            taken_c;

   assign taken_c = xfer_i & br_taken(branch_i, zero_i, uncond_branch_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_src_q    <= 1'b0;
         pc_target_q <= '0;
      end else begin
         pc_src_q <= taken_c;
         if (taken_c) pc_target_q <= target_i;
      end
   end

   assign pc_src_o    = pc_src_q;
   assign pc_target_o = pc_target_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: IDLE/REQ/RESP handshake between execute, data memory and writeback.
// Define MEM_ALIGN_CHK_EN to fault misaligned accesses instead of issuing them.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned WORD     = MEM_WORD,
   parameter int unsigned ADDR_LSB = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [WORD-1:0] alu_result,
   input  logic            zero,
   input  logic [WORD-1:0] branch_target,
   input  logic [WORD-1:0] store_data,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            branch,
   input  logic            uncond_branch,
   input  logic            mem_to_reg,
   input  logic            reg_write,
   input  logic [RD_W-1:0] rd,
   output logic            dm_req,
   output logic            dm_we,
   output logic [WORD-1:0] dm_addr,
   output logic [WORD-1:0] dm_wdata,
   input  logic            dm_ack,
   input  logic [WORD-1:0] dm_rdata,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [WORD-1:0] wb_data,
   output logic [RD_W-1:0] wb_rd,
   output logic            wb_reg_write,
   output logic            wb_fault,
   output logic            pc_src,
   output logic [WORD-1:0] pc_target
);

`ifdef MEM_ALIGN_CHK_EN
   localparam bit ALIGN_CHK_EN = 1'b1;
`else
   localparam bit ALIGN_CHK_EN = 1'b0;
`endif

   logic [1:0]      state_q, state_d;
   logic            ex_ready_q, ex_ready_d;
   logic            dm_req_q, dm_req_d;
   logic            dm_we_q, dm_we_d;
   logic [WORD-1:0] dm_addr_q, dm_addr_d;
   logic [WORD-1:0] dm_wdata_q, dm_wdata_d;
   logic            wb_valid_q, wb_valid_d;
   logic [WORD-1:0] wb_data_q, wb_data_d;
   logic [RD_W-1:0] wb_rd_q, wb_rd_d;
   logic            wb_reg_write_q, wb_reg_write_d;
   logic            wb_fault_q, wb_fault_d;
   logic            mem_to_reg_q, mem_to_reg_d;
   logic            reg_write_q, reg_write_d;
   logic            is_load_q, is_load_d;

   logic xfer_c, access_c, fault_c;

   assign xfer_c   = ex_valid & ex_ready_q;
   assign access_c = mem_read | mem_write;
   assign fault_c  = ALIGN_CHK_EN & (|alu_result[ADDR_LSB-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         ex_ready_q     <= 1'b1;
         dm_req_q       <= 1'b0;
         dm_we_q        <= 1'b0;
         dm_addr_q      <= '0;
         dm_wdata_q     <= '0;
         wb_valid_q     <= 1'b0;
         wb_data_q      <= '0;
         wb_rd_q        <= '0;
         wb_reg_write_q <= 1'b0;
         wb_fault_q     <= 1'b0;
         mem_to_reg_q   <= 1'b0;
         reg_write_q    <= 1'b0;
         is_load_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         ex_ready_q     <= ex_ready_d;
         dm_req_q       <= dm_req_d;
         dm_we_q        <= dm_we_d;
         dm_addr_q      <= dm_addr_d;
         dm_wdata_q     <= dm_wdata_d;
         wb_valid_q     <= wb_valid_d;
         wb_data_q      <= wb_data_d;
         wb_rd_q        <= wb_rd_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_fault_q     <= wb_fault_d;
         mem_to_reg_q   <= mem_to_reg_d;
         reg_write_q    <= reg_write_d;
         is_load_q      <= is_load_d;
      end
   end

   // Next state and next registered outputs; a read+write pair is handled as a store.
   always_comb begin
      state_d        = state_q;
      ex_ready_d     = ex_ready_q;
      dm_req_d       = dm_req_q;
      dm_we_d        = dm_we_q;
      dm_addr_d      = dm_addr_q;
      dm_wdata_d     = dm_wdata_q;
      wb_valid_d     = wb_valid_q;
      wb_data_d      = wb_data_q;
      wb_rd_d        = wb_rd_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_fault_d     = wb_fault_q;
      mem_to_reg_d   = mem_to_reg_q;
      reg_write_d    = reg_write_q;
      is_load_d      = is_load_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_c) begin
               ex_ready_d   = 1'b0;
               wb_data_d    = alu_result;
               wb_rd_d      = rd;
               mem_to_reg_d = mem_to_reg;
               reg_write_d  = reg_write;
               is_load_d    = mem_read & ~mem_write;
               if (access_c && fault_c) begin
                  state_d        = ST_RESP;
                  wb_valid_d     = 1'b1;
                  wb_fault_d     = 1'b1;
                  wb_reg_write_d = 1'b0;
               end else if (access_c) begin
                  state_d    = ST_REQ;
                  dm_req_d   = 1'b1;
                  dm_we_d    = mem_write;
                  dm_addr_d  = alu_result;
                  dm_wdata_d = store_data;
               end else begin
                  state_d        = ST_RESP;
                  wb_valid_d     = 1'b1;
                  wb_reg_write_d = reg_write;
               end
            end
         end
         ST_REQ: begin
            if (dm_ack) begin
               state_d        = ST_RESP;
               dm_req_d       = 1'b0;
               dm_we_d        = 1'b0;
               wb_valid_d     = 1'b1;
               wb_reg_write_d = reg_write_q & is_load_q;
               if (is_load_q && mem_to_reg_q) wb_data_d = dm_rdata;
            end
         end
         ST_RESP: begin
            if (wb_ready) begin
               state_d        = ST_IDLE;
               ex_ready_d     = 1'b1;
               wb_valid_d     = 1'b0;
               wb_reg_write_d = 1'b0;
               wb_fault_d     = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            ex_ready_d = 1'b1;
            dm_req_d   = 1'b0;
            dm_we_d    = 1'b0;
            wb_valid_d = 1'b0;
         end
      endcase
   end

   branch_unit #(.WORD(WORD)) u_branch (
      .clk             (clk),
      .rst_n           (rst_n),
      .xfer_i          (xfer_c),
      .branch_i        (branch),
      .uncond_branch_i (uncond_branch),
      .zero_i          (zero),
      .target_i        (branch_target),
      .pc_src_o        (pc_src),
      .pc_target_o     (pc_target)
   );

   assign ex_ready     = ex_ready_q;
   assign dm_req       = dm_req_q;
   assign dm_we        = dm_we_q;
   assign dm_addr      = dm_addr_q;
   assign dm_wdata     = dm_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_data      = wb_data_q;
   assign wb_rd        = wb_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_fault     = ALIGN_CHK_EN ? wb_fault_q : 1'b0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized operations against a transaction-level model.
module tb_mem_stage;

   localparam int unsigned W = 64;
`ifdef MEM_ALIGN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ex_valid = 1'b0, ex_ready;
   logic [W-1:0] alu_result = '0, branch_target = '0, store_data = '0;
   logic         zero = 1'b0, mem_read = 1'b0, mem_write = 1'b0, branch = 1'b0;
   logic         uncond_branch = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0;
   logic [4:0]   rd = '0;
   logic         dm_req, dm_we;
   logic [W-1:0] dm_addr, dm_wdata;
   logic         dm_ack = 1'b0;
   logic [W-1:0] dm_rdata = '0;
   logic         wb_valid, wb_ready = 1'b0;
   logic [W-1:0] wb_data;
   logic [4:0]   wb_rd;
   logic         wb_reg_write, wb_fault, pc_src;
   logic [W-1:0] pc_target;

   always #5 clk = ~clk;

   mem_stage #(.WORD(W), .ADDR_LSB(3)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
      .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .uncond_branch(uncond_branch), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .rd(rd), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .wb_fault(wb_fault), .pc_src(pc_src),
      .pc_target(pc_target)
   );

   typedef struct {
      logic [W-1:0] alu, tgt, sdata, rdata;
      logic         zero, mrd, mwr, br, ub, m2r, rw;
      logic [4:0]   rd;
   } op_t;

   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   logic         taken_exp = 1'b0;
   logic [W-1:0] cur_target = '0;
   logic [W-1:0] pc_tgt_exp = '0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one cycle; branch outputs are checked every cycle against the model.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (cyc == 1 && taken_exp) pc_tgt_exp = cur_target;
      chk1("pc_src", pc_src, taken_exp && (cyc == 1));
      chk("pc_target", pc_target, pc_tgt_exp);
   endtask

   task automatic scramble();
      alu_result    = {$urandom(), $urandom()};
      branch_target = {$urandom(), $urandom()};
      store_data    = {$urandom(), $urandom()};
      rd            = 5'($urandom());
      {zero, mem_read, mem_write, branch, uncond_branch, mem_to_reg, reg_write} = 7'($urandom());
   endtask

   task automatic chk_wb(input string tag, input logic fault, input logic [W-1:0] d,
                         input logic [4:0] r, input logic rw);
      chk1({tag, "/wb_valid"}, wb_valid, 1'b1);
      chk1({tag, "/dm_req"}, dm_req, 1'b0);
      chk1({tag, "/ex_ready"}, ex_ready, 1'b0);
      if (!fault) chk({tag, "/wb_data"}, wb_data, d);
      chk({tag, "/wb_rd"}, W'(wb_rd), W'(r));
      chk1({tag, "/wb_reg_write"}, wb_reg_write, rw);
      chk1({tag, "/wb_fault"}, wb_fault, fault);
   endtask

   // One complete operation: transfer, optional memory access, writeback with back-pressure.
   task automatic run_op(input string tag, input op_t op, input int ack_dly, input int hold);
      logic         mem, load, fault, issue, exp_rw;
      logic [W-1:0] exp_data;
      int           lat;
      mem      = op.mrd | op.mwr;
      load     = op.mrd & ~op.mwr;
      fault    = CHK && mem && (op.alu[2:0] != 3'd0);
      issue    = mem && !fault;
      exp_data = (load && issue && op.m2r) ? op.rdata : op.alu;
      exp_rw   = op.rw && !op.mwr && !fault;
      lat      = issue ? ack_dly + 1 : 1;

      chk1({tag, "/ex_ready_idle"}, ex_ready, 1'b1);
      alu_result = op.alu; branch_target = op.tgt; store_data = op.sdata;
      zero = op.zero; mem_read = op.mrd; mem_write = op.mwr; branch = op.br;
      uncond_branch = op.ub; mem_to_reg = op.m2r; reg_write = op.rw; rd = op.rd;
      ex_valid = 1'b1;
      wb_ready = (hold == 0);
      taken_exp = (op.br && op.zero) || op.ub;
      cur_target = op.tgt;
      cyc = 0;
      step();
      ex_valid = 1'b0;
      scramble();
      for (int c = 1; c < lat; c++) begin
         chk1({tag, "/dm_req"}, dm_req, 1'b1);
         chk1({tag, "/dm_we"}, dm_we, op.mwr);
         chk({tag, "/dm_addr"}, dm_addr, op.alu);
         chk({tag, "/dm_wdata"}, dm_wdata, op.sdata);
         chk1({tag, "/wb_valid_req"}, wb_valid, 1'b0);
         chk1({tag, "/ex_ready_req"}, ex_ready, 1'b0);
         if (c == ack_dly) begin
            dm_ack = 1'b1;
            dm_rdata = op.rdata;
         end
         step();
         dm_ack = 1'b0;
         dm_rdata = {$urandom(), $urandom()};
      end
      chk_wb(tag, fault, exp_data, op.rd, exp_rw);
      for (int h = 1; h < hold; h++) begin
         dm_ack = 1'($urandom());
         step();
         dm_ack = 1'b0;
         chk_wb({tag, "/hold"}, fault, exp_data, op.rd, exp_rw);
      end
      wb_ready = 1'b1;
      dm_ack = 1'($urandom());
      step();
      dm_ack = 1'b0;
      wb_ready = 1'b0;
      chk1({tag, "/wb_valid_done"}, wb_valid, 1'b0);
      chk1({tag, "/ex_ready_done"}, ex_ready, 1'b1);
      chk1({tag, "/dm_req_done"}, dm_req, 1'b0);
   endtask

   function automatic op_t blank_op();
      op_t o;
      o.alu = '0; o.tgt = '0; o.sdata = '0; o.rdata = '0;
      o.zero = 1'b0; o.mrd = 1'b0; o.mwr = 1'b0; o.br = 1'b0;
      o.ub = 1'b0; o.m2r = 1'b0; o.rw = 1'b0; o.rd = '0;
      return o;
   endfunction

   initial begin
      op_t o;
      int  kind;

      repeat (2) @(negedge clk);
      chk1("rst/ex_ready", ex_ready, 1'b1);
      chk1("rst/dm_req", dm_req, 1'b0);
      chk1("rst/dm_we", dm_we, 1'b0);
      chk1("rst/wb_valid", wb_valid, 1'b0);
      chk1("rst/wb_reg_write", wb_reg_write, 1'b0);
      chk1("rst/wb_fault", wb_fault, 1'b0);
      chk1("rst/pc_src", pc_src, 1'b0);
      chk("rst/dm_addr", dm_addr, '0);
      chk("rst/dm_wdata", dm_wdata, '0);
      chk("rst/wb_data", wb_data, '0);
      chk("rst/wb_rd", W'(wb_rd), '0);
      chk("rst/pc_target", pc_target, '0);
      rst_n = 1'b1;
      @(negedge clk);

      o = blank_op(); o.alu = 64'h2A; o.rw = 1'b1; o.rd = 5'd5;
      run_op("add", o, 1, 0);

      o = blank_op(); o.alu = 64'h100; o.mrd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1;
      o.rd = 5'd9; o.rdata = 64'hDEAD;
      run_op("ldur", o, 3, 0);

      o = blank_op(); o.alu = 64'h108; o.mwr = 1'b1; o.sdata = 64'h55; o.rw = 1'b1; o.rd = 5'd3;
      run_op("stur", o, 1, 0);

      o = blank_op(); o.br = 1'b1; o.zero = 1'b1; o.tgt = 64'h40; o.alu = 64'h7;
      run_op("cbz_taken", o, 1, 0);
      o = blank_op(); o.br = 1'b1; o.zero = 1'b0; o.tgt = 64'h80; o.alu = 64'h9;
      run_op("cbz_not_taken", o, 1, 0);

      o = blank_op(); o.alu = 64'h1234_5678_9ABC_DEF0; o.rw = 1'b1; o.rd = 5'd17;
      run_op("backpressure", o, 1, 4);

      o = blank_op(); o.alu = 64'h103; o.mrd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1;
      o.rd = 5'd4; o.rdata = 64'hBEEF;
      run_op("misaligned", o, 1, 0);

      // Reset in the middle of an outstanding load; the late ack must be ignored.
      alu_result = 64'h200; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      reg_write = 1'b1; rd = 5'd6; branch = 1'b0; uncond_branch = 1'b0;
      ex_valid = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
      chk1("midreq/dm_req_before", dm_req, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk1("midreq/dm_req", dm_req, 1'b0);
      chk1("midreq/ex_ready", ex_ready, 1'b1);
      chk1("midreq/wb_valid", wb_valid, 1'b0);
      chk("midreq/dm_addr", dm_addr, '0);
      @(negedge clk);
      rst_n = 1'b1;
      taken_exp = 1'b0;
      pc_tgt_exp = '0;
      dm_ack = 1'b1;
      dm_rdata = 64'hBAD;
      @(negedge clk);
      dm_ack = 1'b0;
      chk1("late_ack/wb_valid", wb_valid, 1'b0);
      chk1("late_ack/dm_req", dm_req, 1'b0);
      chk1("late_ack/ex_ready", ex_ready, 1'b1);
      chk("late_ack/pc_target", pc_target, '0);

      o = blank_op(); o.alu = 64'h55AA; o.rw = 1'b1; o.rd = 5'd31; o.ub = 1'b1; o.tgt = 64'h4000;
      run_op("after_reset", o, 1, 1);

      for (int n = 0; n < 40; n++) begin
         o.alu   = {$urandom(), $urandom()};
         o.tgt   = {$urandom(), $urandom()};
         o.sdata = {$urandom(), $urandom()};
         o.rdata = {$urandom(), $urandom()};
         o.rd    = 5'($urandom());
         {o.zero, o.br, o.ub, o.rw, o.m2r} = 5'($urandom());
         kind = int'($urandom_range(0, 3));
         o.mrd = (kind == 1) || (kind == 3);
         o.mwr = (kind == 2) || (kind == 3);
         if (o.mwr) o.m2r = 1'b0;
         if ($urandom_range(0, 3) != 0) o.alu[2:0] = 3'd0;
         run_op("rand", o, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
